if_fetch_unit: RTL and testbench

Instruction-fetch stage that produces the `{pc, instr}` packet consumed by the IF/ID pipeline register. It owns the program counter, drives a single-outstanding req/ack instruction-memory port, and absorbs ID-stage stalls with a one-entry skid buffer. It also handles branch/jump redirects, including redirects that arrive while a memory request is in flight. Output is bubble-coded (`instr_o = 0`, `valid_o = 0`), matching the zero-flush convention of IF/ID.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/fetch_skid_buf.sv | 48 ++++
 rtl/if_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the instruction-fetch stage.
//   NOP_INSTR     : bubble instruction word (the IF/ID stage flushes with zeros)
//   INSTR_BYTES   : PC increment per fetched instruction
//   fetch_state_t : fetch FSM states
//   align_pc()    : forces a byte address onto a word boundary
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,   // requesting at pc
        FULL  = 2'd1,   // output stalled, one response parked in the skid buffer
        DRAIN = 2'd2    // redirect seen mid-request; waiting to discard the old response
    } fetch_state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding register for a fetch response that arrives
// while the output packet is stalled.
// Ports:
//   clk_i, rst_n_i    : clock, asynchronous active-low reset
//   load_i            : capture pc_i/instr_i and mark full (wins over clear_i)
//   clear_i           : empty the buffer and zero its contents
//   pc_i, instr_i     : entry to capture
//   pc_o, instr_o     : held entry
//   full_o            : buffer holds a valid entry
module fetch_skid_buf
    import pipeline_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        full_o
);

    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic        full_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_reg    <= 32'h0;
            instr_reg <= NOP_INSTR;
            full_reg  <= 1'b0;
        end else if (load_i) begin
            pc_reg    <= pc_i;
            instr_reg <= instr_i;
            full_reg  <= 1'b1;
        end else if (clear_i) begin
            pc_reg    <= 32'h0;
            instr_reg <= NOP_INSTR;
            full_reg  <= 1'b0;
        end
    end

    assign pc_o    = pc_reg;
    assign instr_o = instr_reg;
    assign full_o  = full_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, runs a single-outstanding req/ack
// instruction-memory port, absorbs ID stalls with a one-entry skid buffer and
// handles redirects, including ones that land while a request is in flight.
// The output packet is bubble-coded: when not valid, pc_o and instr_o are 0.
// Ports:
//   clk_i, rst_n_i           : clock, asynchronous active-low reset
//   stall_i                  : ID hazard stall, hold the current packet
//   redirect_i/redirect_pc_i : taken branch/jump and its target (bits [1:0] ignored)
//   imem_req_o/imem_addr_o   : memory request and word address
//   imem_ack_i/imem_rdata_i  : one-cycle response strobe and instruction word
//   pc_o/instr_o/valid_o     : registered IF/ID packet
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  tgt_reg, tgt_next;
    logic         valid_reg, valid_next;
    logic [31:0]  out_pc_reg, out_pc_next;
    logic [31:0]  out_instr_reg, out_instr_next;

    logic         skid_load, skid_clear, skid_full;
    logic [31:0]  skid_pc, skid_instr;
    logic [31:0]  target;

    fetch_skid_buf u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_reg),
        .instr_i (imem_rdata_i),
        .pc_o    (skid_pc),
        .instr_o (skid_instr),
        .full_o  (skid_full)
    );

    assign target = align_pc(redirect_pc_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= RUN;
            pc_reg        <= RESET_PC;
            tgt_reg       <= 32'h0;
            valid_reg     <= 1'b0;
            out_pc_reg    <= 32'h0;
            out_instr_reg <= NOP_INSTR;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            tgt_reg       <= tgt_next;
            valid_reg     <= valid_next;
            out_pc_reg    <= out_pc_next;
            out_instr_reg <= out_instr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        tgt_next       = tgt_reg;
        valid_next     = valid_reg;
        out_pc_next    = out_pc_reg;
        out_instr_next = out_instr_reg;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        // A consumed packet turns into a bubble unless something replaces it below.
        if (valid_reg && !stall_i) begin
            valid_next     = 1'b0;
            out_pc_next    = 32'h0;
            out_instr_next = NOP_INSTR;
        end

        case (state_reg)
            RUN: begin
                if (redirect_i) begin
                    if (imem_ack_i) begin
                        pc_next = target;           // response belongs to the wrong path
                    end else begin
                        tgt_next   = target;        // must wait out the pending request
                        state_next = DRAIN;
                    end
                end else if (imem_ack_i) begin
                    pc_next = pc_reg + INSTR_BYTES;
                    if (!valid_reg || !stall_i) begin
                        valid_next     = 1'b1;
                        out_pc_next    = pc_reg;
                        out_instr_next = imem_rdata_i;
                    end else begin
                        skid_load  = 1'b1;
                        state_next = FULL;
                    end
                end
            end
            FULL: begin
                if (redirect_i) begin
                    skid_clear = 1'b1;
                    pc_next    = target;
                    state_next = RUN;
                end else if (!stall_i && skid_full) begin
                    valid_next     = 1'b1;
                    out_pc_next    = skid_pc;
                    out_instr_next = skid_instr;
                    skid_clear     = 1'b1;
                    state_next     = RUN;
                end
            end
            DRAIN: begin
                if (redirect_i) begin
                    tgt_next = target;
                end
                if (imem_ack_i) begin
                    pc_next    = redirect_i ? target : tgt_reg;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        // Redirect flushes the packet regardless of stall or ack.
        if (redirect_i) begin
            valid_next     = 1'b0;
            out_pc_next    = 32'h0;
            out_instr_next = NOP_INSTR;
        end
    end

    // Gated by reset so the memory sees req low for the whole reset interval,
    // and rises in the first cycle after release.
    assign imem_req_o  = rst_n_i && (state_reg != FULL);
    assign imem_addr_o = pc_reg;

    assign valid_o = valid_reg;
    assign pc_o    = out_pc_reg;
    assign instr_o = out_instr_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk_i;
    logic        rst_n_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;

    int total = 0;
    int bad   = 0;

    // Expected packet PCs, in consumption order.
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    // Memory model: instruction word at address A is ~A; responds after
    // mem_wait cycles of req being held.
    int   mem_wait;
    logic mem_en;
    int   wait_cnt;

    if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .instr_o       (instr_o),
        .valid_o       (valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    assign imem_ack_i   = mem_en && imem_req_o && (wait_cnt == mem_wait);
    assign imem_rdata_i = imem_ack_i ? ~imem_addr_o : 32'h0;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                      wait_cnt <= 0;
        else if (!imem_req_o || imem_ack_i) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
    end

    // Scoreboard monitor: compares every consumed packet and every bubble.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (valid_o && !stall_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pkt: got pc=%h instr=%h, expected no packet", pc_o, instr_o);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (pc_o !== exp_pc || instr_o !== ~exp_pc) begin
                        bad++;
                        $display("FAIL pkt: got pc=%h instr=%h, expected pc=%h instr=%h",
                                 pc_o, instr_o, exp_pc, ~exp_pc);
                    end else begin
                        $display("pkt pc=%h instr=%h ok", pc_o, instr_o);
                    end
                end
            end else if (!valid_o) begin
                total++;
                if (pc_o !== 32'h0 || instr_o !== 32'h0) begin
                    bad++;
                    $display("FAIL bubble: got pc=%h instr=%h, expected 0/0", pc_o, instr_o);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rpc);
        @(posedge clk_i);
        #1;
        stall_i       = s;
        redirect_i    = r;
        redirect_pc_i = rpc;
        #1;
    endtask

    initial begin
        rst_n_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        mem_wait = 0; mem_en = 1'b1;

        #2;
        chk("rst_req",   {31'b0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'b0, valid_o},    32'd0);
        chk("rst_pc",    pc_o,    32'h0);
        chk("rst_instr", instr_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        #1;
        // C0: zero-wait fetch from RESET_PC
        chk("c0_req",   {31'b0, imem_req_o}, 32'd1);
        chk("c0_addr",  imem_addr_o, 32'h100);
        chk("c0_valid", {31'b0, valid_o}, 32'd0);
        exp_q.push_back(32'h100);
        step(0, 0, 0);                                  // C1
        chk("c1_addr", imem_addr_o, 32'h104);
        exp_q.push_back(32'h104);
        step(1, 0, 0);                                  // C2: stall, 0x108 goes to skid
        chk("c2_addr", imem_addr_o, 32'h108);
        chk("c2_pc",   pc_o, 32'h104);
        exp_q.push_back(32'h108);
        step(1, 0, 0);                                  // C3
        chk("c3_req", {31'b0, imem_req_o}, 32'd0);
        chk("c3_pc",  pc_o, 32'h104);
        step(1, 0, 0);                                  // C4
        chk("c4_req", {31'b0, imem_req_o}, 32'd0);
        chk("c4_pc",  pc_o, 32'h104);
        step(0, 0, 0);                                  // C5: release
        chk("c5_req", {31'b0, imem_req_o}, 32'd0);
        step(0, 1, 32'h10);                             // C6: redirect while acking 0x10C
        chk("c6_pc",   pc_o, 32'h108);
        chk("c6_addr", imem_addr_o, 32'h10C);
        step(0, 0, 0);                                  // C7: req 0x10, 2 wait states
        mem_wait = 2;
        chk("c7_valid", {31'b0, valid_o}, 32'd0);
        chk("c7_addr",  imem_addr_o, 32'h10);
        step(0, 1, 32'h400);                            // C8: redirect mid-request
        chk("c8_addr", imem_addr_o, 32'h10);
        step(0, 0, 0);                                  // C9: DRAIN, old response dropped
        chk("c9_addr",  imem_addr_o, 32'h10);
        chk("c9_req",   {31'b0, imem_req_o}, 32'd1);
        chk("c9_valid", {31'b0, valid_o}, 32'd0);
        step(0, 0, 0);                                  // C10
        chk("c10_addr",  imem_addr_o, 32'h400);
        chk("c10_valid", {31'b0, valid_o}, 32'd0);
        step(0, 0, 0);                                  // C11
        step(0, 0, 0);                                  // C12: ack 0x400
        chk("c12_addr", imem_addr_o, 32'h400);
        step(1, 0, 0);                                  // C13: stall, 0x404 to skid
        mem_wait = 0;
        chk("c13_pc",    pc_o,    32'h400);
        chk("c13_instr", instr_o, 32'hFFFF_FBFF);
        chk("c13_addr",  imem_addr_o, 32'h404);
        step(1, 1, 32'h200);                            // C14: redirect in FULL
        chk("c14_req", {31'b0, imem_req_o}, 32'd0);
        step(0, 0, 0);                                  // C15
        chk("c15_valid", {31'b0, valid_o}, 32'd0);
        chk("c15_addr",  imem_addr_o, 32'h200);
        exp_q.push_back(32'h200);
        step(0, 1, 32'hFFFF_FFFF);                      // C16: unaligned redirect
        chk("c16_pc", pc_o, 32'h200);
        step(0, 0, 0);                                  // C17
        chk("c17_addr", imem_addr_o, 32'hFFFF_FFFC);
        step(1, 0, 0);                                  // C18: hold 0xFFFFFFFC, slow memory
        mem_wait = 3;
        chk("c18_addr",  imem_addr_o, 32'h0);
        chk("c18_pc",    pc_o,    32'hFFFF_FFFC);
        chk("c18_instr", instr_o, 32'h0000_0003);
        step(1, 0, 0);                                  // C19: reset mid-wait
        chk("c19_req", {31'b0, imem_req_o}, 32'd1);
        #1 rst_n_i = 1'b0;
        #1;
        chk("mr_req",   {31'b0, imem_req_o}, 32'd0);
        chk("mr_valid", {31'b0, valid_o}, 32'd0);
        chk("mr_pc",    pc_o,    32'h0);
        chk("mr_instr", instr_o, 32'h0);
        stall_i = 1'b0;
        mem_wait = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        #1;
        chk("r0_addr", imem_addr_o, 32'h100);
        exp_q.push_back(32'h100);
        step(0, 0, 0);
        exp_q.push_back(32'h104);
        step(0, 0, 0);
        mem_en = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
